// File: rtl/shift_chain_ctrl.sv
// Sequencer that pushes a parallel word LSB-first through a serial flop chain and
// collects the returned bits, flagging whether the chain delivered the word intact.
module shift_chain_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    output logic             ser_out,
    input  logic             ser_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             mismatch
);

    localparam int unsigned      CNT_W = $clog2(WIDTH + DEPTH + 1);
    localparam logic [CNT_W-1:0] W_CNT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] D_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH + DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_tx;
    logic [WIDTH-1:0] r_rx;
    logic [WIDTH-1:0] r_ref;
    logic [WIDTH-1:0] r_dout;
    logic             r_mismatch;
    logic [WIDTH-1:0] w_rx_next;
    logic             w_drive;

    assign w_rx_next = {ser_in, r_rx[WIDTH-1:1]};
    assign w_drive   = (r_state == S_SHIFT) && (r_cnt < W_CNT);

    assign ser_out  = w_drive ? r_tx[0] : 1'b0;
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign dout     = r_dout;
    assign mismatch = r_mismatch;

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_SHIFT;
            S_SHIFT: if (r_cnt == LAST) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register and datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_ref      <= '0;
            r_dout     <= '0;
            r_mismatch <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_tx  <= din;
                        r_ref <= din;
                        r_cnt <= '0;
                        r_rx  <= '0;
                    end
                end
                S_SHIFT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt < W_CNT) begin
                        r_tx <= r_tx >> 1;
                    end
                    if (r_cnt >= D_CNT) begin
                        r_rx <= w_rx_next;
                    end
                    // Last sample lands on the exit edge, so publish the updated word
                    if (r_cnt == LAST) begin
                        r_dout     <= w_rx_next;
                        r_mismatch <= (w_rx_next != r_ref);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_chain_ctrl.sv
// Directed and randomized checks of shift_chain_ctrl against a word-level model of
// a serial chain with selectable latency.
module tb_shift_chain_ctrl;

    localparam int unsigned W = 8;
    localparam int unsigned D = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] din;
    logic         ser_out;
    logic         ser_in;
    logic         busy;
    logic         done;
    logic [W-1:0] dout;
    logic         mismatch;

    logic q1 = 1'b0;
    logic q2 = 1'b0;
    int   lat = 2;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_fail = 0;
    int   n_checks = 0;
    int   t_done = 0;
    int   t_prev = 0;

    shift_chain_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .din      (din),
        .ser_out  (ser_out),
        .ser_in   (ser_in),
        .busy     (busy),
        .done     (done),
        .dout     (dout),
        .mismatch (mismatch)
    );

    always #5 clk = ~clk;

    // External chain: two flops, tap after the first one models a latency-1 chain
    always @(posedge clk) begin
        q1  <= ser_out;
        q2  <= q1;
        cyc <= cyc + 1;
    end
    assign ser_in = (lat == 1) ? q1 : q2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bit k is sampled DEPTH cycles after it was driven; a chain of latency l
    // therefore returns sent bit k+DEPTH-l there (zero past the end of the word).
    function automatic logic [W-1:0] model_dout(input logic [W-1:0] d, input int l);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < int'(W); k++) begin
            int idx;
            idx = k + int'(D) - l;
            if (idx >= 0 && idx < int'(W)) r[k] = d[idx];
        end
        return r;
    endfunction

    // Called at a negedge in IDLE; returns at the negedge of the IDLE cycle after DONE.
    task automatic transfer(input logic [W-1:0] d, input bit hold, input bit flip);
        logic [W-1:0] e;
        e     = model_dout(d, lat);
        start = 1'b1;
        din   = d;
        @(negedge clk);
        if (!hold) start = 1'b0;
        for (int c = 0; c < int'(W + D); c++) begin
            logic b;
            b = 1'b0;
            if (c < int'(W)) b = d[c];
            check("busy_shift", 32'(busy), 32'd1);
            check("done_shift", 32'(done), 32'd0);
            check("ser_out", 32'(ser_out), 32'(b));
            if (flip && c == 4) din = '1;
            @(negedge clk);
        end
        check("done_pulse", 32'(done), 32'd1);
        check("busy_done", 32'(busy), 32'd1);
        check("dout", 32'(dout), 32'(e));
        check("mismatch", 32'(mismatch), 32'(e != d));
        t_prev = t_done;
        t_done = cyc;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("dout_hold", 32'(dout), 32'(e));
        start = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        din   = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ser_out", 32'(ser_out), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_mismatch", 32'(mismatch), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Nominal transfer through the correct chain
        transfer(8'hA5, 1'b0, 1'b0);

        // start held high, din changed mid-shift: one transfer of the captured word
        transfer(8'h3C, 1'b1, 1'b1);
        @(negedge clk);
        check("hold_no_restart", 32'(busy), 32'd0);

        // Chain one cycle shorter than expected
        lat = 1;
        transfer(8'h0F, 1'b0, 1'b0);
        lat = 2;

        // Abort at cnt==4 with start also high; rst wins and clears results
        start = 1'b1;
        din   = 8'hC3;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_abort_busy", 32'(busy), 32'd1);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_ser_out", 32'(ser_out), 32'd0);
        check("abort_dout", 32'(dout), 32'd0);
        check("abort_mismatch", 32'(mismatch), 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("post_abort_idle", 32'(busy), 32'd0);
        transfer(8'h5A, 1'b0, 1'b0);

        // Back-to-back transfers restarting as soon as IDLE is reached
        transfer(8'hFF, 1'b0, 1'b0);
        transfer(8'h00, 1'b0, 1'b0);
        check("b2b_spacing", 32'(t_done - t_prev), 32'd12);

        // Random words through the correct chain
        for (int i = 0; i < 16; i++) begin
            transfer(W'($urandom), 1'b0, 1'b0);
        end

        // Random words through the short chain
        lat = 1;
        for (int i = 0; i < 4; i++) begin
            transfer(W'($urandom), 1'b0, 1'b0);
        end
        lat = 2;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
